signal_field_decoder: RTL and testbench
=======================================

// Module: signal_field_decoder
// PURPOSE
//  Consumes the 24 Viterbi-decoded bits of the 802.11a SIGNAL symbol, one bit per strobe (LSB/R1 first).
//  Validates parity, RATE code, tail and LENGTH, and decodes RATE into per-rate constants.
//  Computes N_SYM = ceil((16 + 8*LENGTH + 6) / N_DBPS) for the DATA-field deinterleaver/depuncturer control.
// PARAMETERS
//  LEN_W   12  LENGTH field width (octets)
//  NSYM_W  11  width of n_sym_o (max 1366 at 6 Mbps, LENGTH 4095)
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high; single clock domain
//  start_i      in   1       arm decoder for a new SIGNAL field (honoured in IDLE only)
//  abort_i      in   1       synchronous return to IDLE from any state; outputs hold last values
//  bit_valid_i  in   1       bit_i valid this cycle (honoured in COLLECT only)
//  bit_i        in   1       decoded SIGNAL bit, transmit order
//  busy_o       out  1       high in every state except IDLE
//  sig_done_o   out  1       one-cycle pulse: results below valid and stable until next start_i
//  sig_ok_o     out  1       no error flag set
//  parity_err_o out  1       XOR of bits 0..17 != 0 (even parity)
//  rate_err_o   out  1       RATE not one of the 8 legal codes
//  tail_err_o   out  1       any of bits 18..23 nonzero
//  len_err_o    out  1       LENGTH == 0
//  rate_o       out  4       RATE, rate_o[0]=R1 (first received)
//  length_o     out  LEN_W   LENGTH, length_o[0]=bit 5
//  n_dbps_o     out  8       data bits per OFDM symbol
//  n_cbps_o     out  9       coded bits per OFDM symbol
//  n_bpsc_o     out  3       bits per subcarrier (1,2,4,6)
//  n_sym_o      out  NSYM_W  DATA OFDM symbol count (0 if any error)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, bit counter 0, shift register 0.
//  FSM: IDLE -start_i-> COLLECT -24th bit-> CHECK -ok-> DIVIDE -done-> DONE -> IDLE; CHECK -error-> DONE.
//  COLLECT: each bit_valid_i shifts bit_i in at MSB of a 24-bit register (bit 0 ends at LSB); 5-bit counter.
//  Gaps in bit_valid_i permitted; counter advances only on strobe; exactly 24 accepted bits.
//  CHECK (1 cycle): latch rate_o, length_o, LUT outputs, all four error flags; remainder r = 22 + 8*LENGTH (16 bits).
//  RATE map R1R2R3R4 -> Mbps/N_DBPS/N_CBPS/N_BPSC:
//   1101 6/24/48/1   1111 9/36/48/1   0101 12/48/96/2   0111 18/72/96/2
//   1001 24/96/192/4 1011 36/144/192/4 0001 48/192/288/6 0011 54/216/288/6
//  Illegal RATE: rate_err_o=1, n_dbps/n_cbps/n_bpsc forced 0, divide skipped.
//  DIVIDE: one step per cycle: n_sym += 1; if r <= n_dbps then exit, else r -= n_dbps. Takes N_SYM cycles.
//  DONE: sig_done_o=1 for exactly one cycle; sig_ok_o = ~(parity|rate|tail|len errors).
//  Latency: 24th bit accepted at edge T -> sig_done_o high in cycle T+2+N_SYM (ok) or T+2 (error).
//  start_i while busy: ignored. start_i and abort_i together in IDLE: abort wins, stay IDLE.
//  abort_i: next cycle IDLE, busy_o=0, no sig_done_o pulse; counter/remainder cleared.
//  start_i in IDLE clears error flags, sig_ok_o and n_sym_o; rate_o/length_o hold until CHECK.
//  Async reset mid-COLLECT/DIVIDE: immediate return to reset values; no partial pulse.
//  All arithmetic unsigned; r fits 16 bits (max 32782); no overflow possible in n_sym.
// STRUCTURE
//  Package wlan_sig_pkg: sig_state_t enum (IDLE,COLLECT,CHECK,DIVIDE,DONE), SIG_BITS=24,
//   SERVICE_TAIL_BITS=22, rate-code localparams, rate_params_t struct {n_dbps,n_cbps,n_bpsc,valid}.
//  Sub-module signal_rate_decode: combinational RATE -> rate_params_t table; instantiated once.
// TESTING
//  6 Mbps (R=1101), LENGTH=1, good parity/tail -> n_dbps=24, n_sym=2, sig_ok=1, done at T+4.
//  36 Mbps (1011), LENGTH=100, bit_valid gaps of 3 cycles -> n_dbps=144, n_cbps=192, n_sym=6.
//  54 Mbps (0011), LENGTH=4095 -> n_sym=152; 6 Mbps LENGTH=4095 -> n_sym=1366, busy throughout.
//  Flipped parity bit -> parity_err=1, sig_ok=0, n_sym=0, done at T+2; RATE=0000 -> rate_err=1.
//  Tail bit 20 set -> tail_err=1; LENGTH=0 -> len_err=1; both: both flags set, sig_ok=0.
//  abort_i after 10 bits, then start_i + fresh 24 bits -> clean result; reset asserted mid-DIVIDE -> all outputs 0.

Source files
------------

// File: rtl/wlan_sig_pkg.sv
// Shared types and constants for the 802.11a SIGNAL field decoder.
// Rate codes are stored the way they land in rate_o: bit 0 holds R1, the
// first bit on air, so the table's "R1R2R3R4" strings are reversed below.
package wlan_sig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    DIVIDE,
    DONE
  } sig_state_t;

  localparam int SIG_BITS          = 24;
  localparam int SERVICE_TAIL_BITS = 22;  // 16 SERVICE + 6 tail bits

  // Bit positions inside the collected SIGNAL word (bit 0 = first received)
  localparam int RATE_LSB   = 0;
  localparam int LEN_LSB    = 5;
  localparam int PARITY_BIT = 17;
  localparam int TAIL_LSB   = 18;

  // Convert an on-air "R1R2R3R4" string (R1 as MSB) into rate_o ordering
  function automatic logic [3:0] tx_order(input logic [3:0] r1r2r3r4);
    return {r1r2r3r4[0], r1r2r3r4[1], r1r2r3r4[2], r1r2r3r4[3]};
  endfunction

  localparam logic [3:0] RATE_6M  = tx_order(4'b1101);
  localparam logic [3:0] RATE_9M  = tx_order(4'b1111);
  localparam logic [3:0] RATE_12M = tx_order(4'b0101);
  localparam logic [3:0] RATE_18M = tx_order(4'b0111);
  localparam logic [3:0] RATE_24M = tx_order(4'b1001);
  localparam logic [3:0] RATE_36M = tx_order(4'b1011);
  localparam logic [3:0] RATE_48M = tx_order(4'b0001);
  localparam logic [3:0] RATE_54M = tx_order(4'b0011);

  typedef struct packed {
    logic [7:0] n_dbps;
    logic [8:0] n_cbps;
    logic [2:0] n_bpsc;
    logic       valid;
  } rate_params_t;

endpackage

// File: rtl/signal_rate_decode.sv
// Combinational RATE lookup: maps the 4-bit RATE field to the per-rate
// OFDM constants. Illegal codes return all zeros with valid cleared.
module signal_rate_decode
  import wlan_sig_pkg::*;
(
  input  logic [3:0]   rate,
  output rate_params_t params
);

  // Rate table; unknown codes fall through to the all-zero default
  always_comb begin
    params = '0;
    case (rate)
      RATE_6M:  params = '{n_dbps: 8'd24,  n_cbps: 9'd48,  n_bpsc: 3'd1, valid: 1'b1};
      RATE_9M:  params = '{n_dbps: 8'd36,  n_cbps: 9'd48,  n_bpsc: 3'd1, valid: 1'b1};
      RATE_12M: params = '{n_dbps: 8'd48,  n_cbps: 9'd96,  n_bpsc: 3'd2, valid: 1'b1};
      RATE_18M: params = '{n_dbps: 8'd72,  n_cbps: 9'd96,  n_bpsc: 3'd2, valid: 1'b1};
      RATE_24M: params = '{n_dbps: 8'd96,  n_cbps: 9'd192, n_bpsc: 3'd4, valid: 1'b1};
      RATE_36M: params = '{n_dbps: 8'd144, n_cbps: 9'd192, n_bpsc: 3'd4, valid: 1'b1};
      RATE_48M: params = '{n_dbps: 8'd192, n_cbps: 9'd288, n_bpsc: 3'd6, valid: 1'b1};
      RATE_54M: params = '{n_dbps: 8'd216, n_cbps: 9'd288, n_bpsc: 3'd6, valid: 1'b1};
      default:  params = '0;
    endcase
  end

endmodule

// File: rtl/signal_field_decoder.sv
// 802.11a SIGNAL field decoder: collects the 24 decoded SIGNAL bits,
// checks parity/RATE/tail/LENGTH, and derives N_SYM by repeated
// subtraction of N_DBPS from (16 + 8*LENGTH + 6), one step per cycle.
module signal_field_decoder
  import wlan_sig_pkg::*;
#(
  parameter int LEN_W  = 12,
  parameter int NSYM_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              bit_valid_i,
  input  logic              bit_i,
  output logic              busy_o,
  output logic              sig_done_o,
  output logic              sig_ok_o,
  output logic              parity_err_o,
  output logic              rate_err_o,
  output logic              tail_err_o,
  output logic              len_err_o,
  output logic [3:0]        rate_o,
  output logic [LEN_W-1:0]  length_o,
  output logic [7:0]        n_dbps_o,
  output logic [8:0]        n_cbps_o,
  output logic [2:0]        n_bpsc_o,
  output logic [NSYM_W-1:0] n_sym_o
);

  sig_state_t            state;
  sig_state_t            state_next;
  logic [SIG_BITS-1:0]   shreg;
  logic [4:0]            bit_cnt;
  logic [15:0]           remainder;
  logic [NSYM_W-1:0]     sym_cnt;
  rate_params_t          rate_params;

  logic                  last_bit;
  logic                  parity_bad;
  logic                  tail_bad;
  logic                  len_bad;
  logic                  rate_bad;
  logic                  check_err;
  logic                  div_last;
  logic [15:0]           rem_init;

  // The RATE field sits in the low nibble once all 24 bits are in
  signal_rate_decode u_rate_decode (
    .rate   (shreg[RATE_LSB +: 4]),
    .params (rate_params)
  );

  assign last_bit   = bit_valid_i && (bit_cnt == 5'(SIG_BITS - 1));
  assign parity_bad = ^shreg[PARITY_BIT:0];
  assign tail_bad   = |shreg[SIG_BITS-1:TAIL_LSB];
  assign len_bad    = (shreg[LEN_LSB +: LEN_W] == '0);
  assign rate_bad   = ~rate_params.valid;
  assign check_err  = parity_bad | tail_bad | len_bad | rate_bad;

  // Bits still to cover before this step: when they fit in one symbol we stop
  assign div_last   = (remainder <= {8'd0, n_dbps_o});
  assign rem_init   = 16'(SERVICE_TAIL_BITS) + 16'({shreg[LEN_LSB +: LEN_W], 3'b000});

  assign busy_o     = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides everything, including a start in IDLE
  always_comb begin
    state_next = state;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_next = COLLECT;
        COLLECT: if (last_bit) state_next = CHECK;
        CHECK:   state_next = check_err ? DONE : DIVIDE;
        DIVIDE:  if (div_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit collection, field latching, division datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      remainder    <= '0;
      sym_cnt      <= '0;
      sig_done_o   <= 1'b0;
      sig_ok_o     <= 1'b0;
      parity_err_o <= 1'b0;
      rate_err_o   <= 1'b0;
      tail_err_o   <= 1'b0;
      len_err_o    <= 1'b0;
      rate_o       <= '0;
      length_o     <= '0;
      n_dbps_o     <= '0;
      n_cbps_o     <= '0;
      n_bpsc_o     <= '0;
      n_sym_o      <= '0;
    end else begin
      sig_done_o <= 1'b0;
      if (abort_i) begin
        // Results stay as they were; only the in-flight work is dropped
        bit_cnt   <= '0;
        remainder <= '0;
        sym_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              bit_cnt      <= '0;
              sym_cnt      <= '0;
              sig_ok_o     <= 1'b0;
              parity_err_o <= 1'b0;
              rate_err_o   <= 1'b0;
              tail_err_o   <= 1'b0;
              len_err_o    <= 1'b0;
              n_sym_o      <= '0;
            end
          end
          COLLECT: begin
            if (bit_valid_i) begin
              // New bit enters at the top so the first bit ends up at bit 0
              shreg   <= {bit_i, shreg[SIG_BITS-1:1]};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          CHECK: begin
            rate_o       <= shreg[RATE_LSB +: 4];
            length_o     <= shreg[LEN_LSB +: LEN_W];
            n_dbps_o     <= rate_params.n_dbps;
            n_cbps_o     <= rate_params.n_cbps;
            n_bpsc_o     <= rate_params.n_bpsc;
            parity_err_o <= parity_bad;
            rate_err_o   <= rate_bad;
            tail_err_o   <= tail_bad;
            len_err_o    <= len_bad;
            remainder    <= rem_init;
            sym_cnt      <= '0;
            bit_cnt      <= '0;
          end
          DIVIDE: begin
            sym_cnt <= sym_cnt + NSYM_W'(1);
            if (!div_last) begin
              remainder <= remainder - {8'd0, n_dbps_o};
            end
          end
          DONE: begin
            sig_done_o <= 1'b1;
            sig_ok_o   <= ~(parity_err_o | rate_err_o | tail_err_o | len_err_o);
            n_sym_o    <= (parity_err_o | rate_err_o | tail_err_o | len_err_o)
                          ? '0 : sym_cnt;
            remainder  <= '0;
          end
          default: begin
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signal_field_decoder.sv
// Testbench for signal_field_decoder: builds SIGNAL words from field values,
// predicts results with a ceil-division reference model and compares.
module tb_signal_field_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        abort_i;
  logic        bit_valid_i;
  logic        bit_i;
  logic        busy_o;
  logic        sig_done_o;
  logic        sig_ok_o;
  logic        parity_err_o;
  logic        rate_err_o;
  logic        tail_err_o;
  logic        len_err_o;
  logic [3:0]  rate_o;
  logic [11:0] length_o;
  logic [7:0]  n_dbps_o;
  logic [8:0]  n_cbps_o;
  logic [2:0]  n_bpsc_o;
  logic [10:0] n_sym_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    int          latency;
    logic        ok;
    logic        perr;
    logic        rerr;
    logic        terr;
    logic        lerr;
    logic [3:0]  rate;
    logic [11:0] length;
    logic [7:0]  dbps;
    logic [8:0]  cbps;
    logic [2:0]  bpsc;
    logic [10:0] nsym;
    logic        pulse_extra;
    logic        held;
    logic        busy_ok;
  } result_t;

  // Reference rate table, codes written R1R2R3R4 with R1 as MSB
  logic [3:0] code_tab [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                               4'b1001, 4'b1011, 4'b0001, 4'b0011};
  int dbps_tab [8] = '{24, 36, 48, 72, 96, 144, 192, 216};
  int cbps_tab [8] = '{48, 48, 96, 96, 192, 192, 288, 288};
  int bpsc_tab [8] = '{1, 1, 2, 2, 4, 4, 6, 6};

  signal_field_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .bit_valid_i  (bit_valid_i),
    .bit_i        (bit_i),
    .busy_o       (busy_o),
    .sig_done_o   (sig_done_o),
    .sig_ok_o     (sig_ok_o),
    .parity_err_o (parity_err_o),
    .rate_err_o   (rate_err_o),
    .tail_err_o   (tail_err_o),
    .len_err_o    (len_err_o),
    .rate_o       (rate_o),
    .length_o     (length_o),
    .n_dbps_o     (n_dbps_o),
    .n_cbps_o     (n_cbps_o),
    .n_bpsc_o     (n_bpsc_o),
    .n_sym_o      (n_sym_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Assemble a SIGNAL word (index 0 = first bit on air) with even parity
  function automatic logic [23:0] make_frame(input logic [3:0] code, input int len,
                                             input logic [5:0] tail, input bit flip);
    logic [23:0] f;
    f       = '0;
    f[0]    = code[3];
    f[1]    = code[2];
    f[2]    = code[1];
    f[3]    = code[0];
    f[16:5] = len[11:0];
    f[17]   = (^f[16:0]) ^ flip;
    f[23:18] = tail;
    return f;
  endfunction

  // Expected decoder result from the field rules and N_SYM = ceil(bits / N_DBPS)
  function automatic result_t model(input logic [23:0] f);
    result_t    e;
    logic [3:0] code;
    int         idx;
    int         len;
    e    = '0;
    code = {f[0], f[1], f[2], f[3]};
    idx  = -1;
    for (int k = 0; k < 8; k++) if (code_tab[k] == code) idx = k;
    len    = int'(f[16:5]);
    e.perr = ^f[17:0];
    e.rerr = (idx < 0);
    e.terr = |f[23:18];
    e.lerr = (len == 0);
    e.ok   = !(e.perr || e.rerr || e.terr || e.lerr);
    e.rate = f[3:0];
    e.length = f[16:5];
    if (idx >= 0) begin
      e.dbps = 8'(dbps_tab[idx]);
      e.cbps = 9'(cbps_tab[idx]);
      e.bpsc = 3'(bpsc_tab[idx]);
    end
    if (e.ok) e.nsym = 11'((16 + 8 * len + 6 + dbps_tab[idx] - 1) / dbps_tab[idx]);
    e.latency     = 2 + int'(e.nsym);
    e.pulse_extra = 1'b0;
    e.held        = 1'b1;
    e.busy_ok     = 1'b1;
    return e;
  endfunction

  // Pulse start then feed 24 bits with optional strobe gaps; t0 = edge of 24th bit
  task automatic send_frame(input logic [23:0] f, input int gap, input bit noisy, output int t0);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i != 0) @(negedge clk);
      if (gap > 0) begin
        bit_valid_i = 1'b0;
        bit_i       = 1'($urandom);
        for (int g = 0; g < gap; g++) @(negedge clk);
      end
      bit_valid_i = 1'b1;
      bit_i       = f[i];
      start_i     = noisy ? 1'($urandom) : 1'b0;
    end
    @(posedge clk);
    #1;
    t0          = cyc;
    bit_valid_i = 1'b0;
    start_i     = 1'b0;
  endtask

  // Wait (bounded) for sig_done_o, snapshot results, then look one cycle later
  task automatic wait_done(input int t0, output result_t o);
    bit got;
    o         = '0;
    o.latency = -1;
    o.busy_ok = 1'b1;
    got       = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk);
      #1;
      if (sig_done_o) got = 1'b1;
      else if (!busy_o) o.busy_ok = 1'b0;
    end
    if (got) o.latency = cyc - t0;
    o.ok     = sig_ok_o;
    o.perr   = parity_err_o;
    o.rerr   = rate_err_o;
    o.terr   = tail_err_o;
    o.lerr   = len_err_o;
    o.rate   = rate_o;
    o.length = length_o;
    o.dbps   = n_dbps_o;
    o.cbps   = n_cbps_o;
    o.bpsc   = n_bpsc_o;
    o.nsym   = n_sym_o;
    @(posedge clk);
    #1;
    o.pulse_extra = sig_done_o;
    o.held = (n_sym_o === o.nsym) && (sig_ok_o === o.ok) && (rate_o === o.rate)
             && (length_o === o.length);
  endtask

  task automatic test_reset();
    logic [54:0] outs;
    outs = {busy_o, sig_done_o, sig_ok_o, parity_err_o, rate_err_o, tail_err_o, len_err_o,
            rate_o, length_o, n_dbps_o, n_cbps_o, n_bpsc_o, n_sym_o, 8'h00};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || sig_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b done=%b want 0/0", busy_o, sig_done_o);
    end
  endtask

  // Known rates: 6M LENGTH=1, 36M LENGTH=100 with 3-cycle gaps, and all other codes
  task automatic test_rate_table();
    logic [23:0] frames[$];
    int          gaps[$];
    result_t     exp, obs;
    int          t0;
    frames.push_back(make_frame(4'b1101, 1, 6'd0, 1'b0));   gaps.push_back(0);
    frames.push_back(make_frame(4'b1011, 100, 6'd0, 1'b0)); gaps.push_back(3);
    for (int k = 0; k < 8; k++) begin
      frames.push_back(make_frame(code_tab[k], int'($urandom_range(1, 300)), 6'd0, 1'b0));
      gaps.push_back(int'($urandom_range(0, 1)));
    end
    foreach (frames[i]) begin
      exp = model(frames[i]);
      send_frame(frames[i], gaps[i], 1'b0, t0);
      wait_done(t0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rate_table[%0d] got=%p want=%p", i, obs, exp);
      end
      $display("rate_table[%0d] rate=%b len=%0d n_sym=%0d lat=%0d", i, obs.rate, obs.length,
               obs.nsym, obs.latency);
    end
  endtask

  // Longest frames: N_SYM 152 at 54M and 1366 at 6M, busy must stay high
  task automatic test_long_frames();
    logic [23:0] frames[2];
    result_t     exp, obs;
    int          t0;
    frames[0] = make_frame(4'b0011, 4095, 6'd0, 1'b0);
    frames[1] = make_frame(4'b1101, 4095, 6'd0, 1'b0);
    foreach (frames[i]) begin
      exp = model(frames[i]);
      send_frame(frames[i], 0, 1'b0, t0);
      wait_done(t0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_frame[%0d] got=%p want=%p", i, obs, exp);
      end
      $display("long_frame[%0d] n_sym=%0d lat=%0d", i, obs.nsym, obs.latency);
    end
  endtask

  // Parity flip, illegal RATE, tail bit 20, LENGTH 0, tail+LENGTH 0
  task automatic test_errors();
    logic [23:0] frames[5];
    result_t     exp, obs;
    int          t0;
    frames[0] = make_frame(4'b1101, 50, 6'd0, 1'b1);
    frames[1] = make_frame(4'b0000, 50, 6'd0, 1'b0);
    frames[2] = make_frame(4'b0101, 50, 6'b000100, 1'b0);
    frames[3] = make_frame(4'b1001, 0, 6'd0, 1'b0);
    frames[4] = make_frame(4'b0111, 0, 6'b000100, 1'b0);
    foreach (frames[i]) begin
      exp = model(frames[i]);
      send_frame(frames[i], 0, 1'b0, t0);
      wait_done(t0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL error_frame[%0d] got=%p want=%p", i, obs, exp);
      end
      $display("error_frame[%0d] p=%b r=%b t=%b l=%b ok=%b lat=%0d", i, obs.perr, obs.rerr,
               obs.terr, obs.lerr, obs.ok, obs.latency);
    end
  endtask

  // Abort after 10 bits: idle next cycle, no pulse, old fields held; then a clean frame
  task automatic test_abort();
    logic [23:0] f;
    result_t     exp, obs;
    int          t0;
    bit          pulsed;
    f = make_frame(4'b0101, 77, 6'd0, 1'b0);
    send_frame(f, 0, 1'b0, t0);
    wait_done(t0, obs);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_valid_i = 1'b1;
      bit_i       = 1'($urandom);
      @(negedge clk);
    end
    bit_valid_i = 1'b0;
    abort_i     = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || length_o !== 12'd77 || n_sym_o !== 11'd0) begin
      errors++;
      $display("FAIL abort_state busy=%b len=%0d n_sym=%0d want 0/77/0", busy_o, length_o, n_sym_o);
    end
    pulsed = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (sig_done_o) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL abort_no_pulse got=1 want=0");
    end
    f   = make_frame(4'b1111, 222, 6'd0, 1'b0);
    exp = model(f);
    send_frame(f, 1, 1'b0, t0);
    wait_done(t0, obs);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_recover got=%p want=%p", obs, exp);
    end
    $display("abort_recover n_sym=%0d lat=%0d", obs.nsym, obs.latency);
  endtask

  // start_i and abort_i together in IDLE: abort wins
  task automatic test_start_abort_idle();
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle busy got=%b want=0", busy_o);
    end
  endtask

  // Randomized back-to-back frames with gaps, start_i noise, occasional corruption
  task automatic test_random_back_to_back();
    logic [23:0] f;
    logic [3:0]  code;
    result_t     exp, obs;
    int          t0;
    for (int n = 0; n < 30; n++) begin
      code = ($urandom_range(0, 9) == 0) ? 4'($urandom) : code_tab[$urandom_range(0, 7)];
      f = make_frame(code, int'($urandom_range(0, 500)),
                     ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0,
                     ($urandom_range(0, 9) == 0));
      exp = model(f);
      send_frame(f, int'($urandom_range(0, 2)), 1'b1, t0);
      wait_done(t0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d] got=%p want=%p", n, obs, exp);
      end
      $display("random[%0d] rate=%b len=%0d ok=%b n_sym=%0d", n, obs.rate, obs.length, obs.ok,
               obs.nsym);
    end
  endtask

  // Reset mid-DIVIDE clears all outputs at once; decoder works afterwards
  task automatic test_reset_mid_divide();
    logic [23:0] f;
    logic [54:0] outs;
    result_t     exp, obs;
    int          t0;
    bit          pulsed;
    f = make_frame(4'b1101, 4095, 6'd0, 1'b0);
    send_frame(f, 0, 1'b0, t0);
    repeat (100) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    outs = {busy_o, sig_done_o, sig_ok_o, parity_err_o, rate_err_o, tail_err_o, len_err_o,
            rate_o, length_o, n_dbps_o, n_cbps_o, n_bpsc_o, n_sym_o, 8'h00};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_divide got=%h want=0", outs);
    end
    pulsed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (sig_done_o || busy_o) pulsed = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (sig_done_o || busy_o) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL reset_quiet got activity want none");
    end
    f   = make_frame(4'b1001, 1000, 6'd0, 1'b0);
    exp = model(f);
    send_frame(f, 0, 1'b0, t0);
    wait_done(t0, obs);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_recover got=%p want=%p", obs, exp);
    end
    $display("reset_recover n_sym=%0d lat=%0d", obs.nsym, obs.latency);
  endtask

  initial begin
    reset       = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    bit_valid_i = 1'b0;
    bit_i       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_rate_table();
    test_long_frames();
    test_errors();
    test_abort();
    test_start_abort_idle();
    test_random_back_to_back();
    test_reset_mid_divide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
